mdu_multicycle: RTL and testbench
=================================

// Module: mdu_multicycle
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit with HI/LO registers, for the EX stage of the pipelined CPU.
//  Accepts one mult/div op at a time and holds busy for a fixed, op-dependent latency.
//  Supports cancel (exception flush) and deterministic div-by-zero and overflow results.
//  Serves mthi/mtlo/mfhi/mflo.
// PARAMETERS
//  WIDTH    32  operand / HI / LO width
//  MUL_LAT  5   busy cycles for mult/multu/madd*/msub* (>=1)
//  DIV_LAT  10  busy cycles for div/divu (>=1)
// PORTS
//  clk      in   1      clock; all state changes on posedge
//  reset    in   1      synchronous, active-low reset (sampled on posedge clk; 0 = reset)
//  start    in   1      issue strobe; op/src_a/src_b valid while high
//  op       in   4      mdu_pkg::mdu_op_e operation code
//  src_a    in   WIDTH  rs operand (dividend; mthi/mtlo data)
//  src_b    in   WIDTH  rt operand (divisor)
//  cancel   in   1      flush: abort in-flight op, block issue this cycle
//  busy     out  1      op in flight; hazard unit stalls MDU ops while high
//  hi       out  WIDTH  architectural HI
//  lo       out  WIDTH  architectural LO
//  rd_data  out  WIDTH  combinational: hi if op==MFHI, lo if op==MFLO, else 0
// BEHAVIOUR
//  - Reset (reset==0 at posedge): hi=lo=0, busy=0, cnt=0, state=IDLE, staged result=0. Aborts any op in flight.
//  - FSM: IDLE -> BUSY on an accepted start of a mult/div-class op.
//    BUSY -> IDLE when cnt reaches 1 (commit) or on cancel (abort).
//  - Accept rule: start && !busy && !cancel && state==IDLE. Otherwise start is ignored; no queueing.
//  - Accept at edge T0:
//    - Compute the full 2*WIDTH result into staging regs.
//    - Load cnt = LAT; busy=1 from T0 through edge T0+LAT.
//    - At edge T0+LAT: hi/lo <= staged result and busy <= 0 at the same time.
//    - New hi/lo is visible in the first cycle busy reads 0.
//  - mult: signed {hi,lo}=a*b. multu: unsigned. Product width 2*WIDTH, no truncation.
//  - div: lo=a/b, hi=a%b, signed, truncating toward zero; remainder takes the dividend's sign. divu: unsigned.
//  - Div by zero (src_b==0): still takes DIV_LAT cycles; hi/lo left unchanged at commit.
//  - Signed overflow (a=MIN_INT, b=-1): lo=MIN_INT, hi=0. No trap.
//  - mthi/mtlo: only when !busy && !cancel. Write hi/lo (=src_a) at that edge, 1 cycle, busy stays 0.
//  - mfhi/mflo: pure read via rd_data, no state change.
//  - Cancel while BUSY: at that edge state->IDLE, busy<=0, cnt<=0, hi/lo keep old values.
//  - Cancel on the commit edge (cnt==1): cancel wins and there is no commit.
//  - start and cancel in the same cycle: nothing accepted, nothing written.
//  - Counter width: $clog2(max(MUL_LAT,DIV_LAT)+1).
//  - op values outside the enum: treated as NONE.
// CONFIGURATION
//  MDU_MADD_EN defined:
//    - Enables MADD/MADDU/MSUB/MSUBU.
//    - {hi,lo} at commit = {hi,lo}_at_commit +/- (a*b), signed or unsigned per op, latency MUL_LAT.
//    - Accumulation uses hi/lo as of the commit edge.
//  MDU_MADD_EN undefined: those codes are treated as NONE (ignored, busy stays 0).
// STRUCTURE
//  - mdu_pkg: mdu_op_e enum, 4 bits:
//    NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8,
//    MADD=9, MADDU=10, MSUB=11, MSUBU=12.
//  - mdu_pkg also holds the is_mul/is_div class helper functions and the state enum (IDLE, BUSY).
//  - One sub-module: mdu_arith. Combinational WIDTH-generic mul/div core returning {hi,lo}.
//    It owns all sign, div-by-zero and overflow rules.
// TESTING
//  1. Reset: reset=0 for 2 cycles, then 1 -> hi=lo=0, busy=0, rd_data=0.
//  2. mult a=-3, b=7 (MUL_LAT=5): busy high exactly 5 cycles, then hi=FFFFFFFF, lo=FFFFFFEB.
//     multu same operands: hi=00000006, lo=FFFFFFEB.
//  3. div a=-7, b=2: after 10 busy cycles lo=FFFFFFFD, hi=FFFFFFFF.
//     div a=80000000, b=FFFFFFFF: lo=80000000, hi=0.
//     divu a=5, b=0: hi/lo unchanged.
//  4. Start div, assert cancel on busy cycle 4: busy drops the next edge, hi/lo keep prior values.
//     start+cancel together: busy stays 0.
//  5. mtlo 0x1234 while idle: lo=0x1234 next cycle, mflo rd_data=0x1234.
//     mthi issued while busy: ignored.
//     Start issued while busy: ignored; result equals the first op's.
//  6. MDU_MADD_EN: hi=0, lo=10, then madd a=2, b=3 -> lo=16 after MUL_LAT cycles.
//     Without the macro: op=9 leaves busy=0 and hi/lo unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and op-class helpers for the multi-cycle multiply/divide unit.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MFHI  = 4'd7,
        MFLO  = 4'd8,
        MADD  = 4'd9,
        MADDU = 4'd10,
        MSUB  = 4'd11,
        MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // How the staged result lands in {hi,lo} at commit
    typedef enum logic [1:0] {
        ACC_LOAD = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2,
        ACC_KEEP = 2'd3
    } acc_e;

    function automatic logic is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
`else
        return op inside {MULT, MULTU};
`endif
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op inside {DIV, DIVU};
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide core returning a full {hi,lo} result.
// Owns sign handling, divide-by-zero (keep) and MIN_INT/-1 overflow.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] res,
    output logic               keep
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0]      sa;
    logic [2*WIDTH-1:0]      sb;
    logic [2*WIDTH-1:0]      ua;
    logic [2*WIDTH-1:0]      ub;
    logic signed [WIDTH-1:0] quo;
    logic signed [WIDTH-1:0] rem;

    assign sa = {{WIDTH{a[WIDTH-1]}}, a};
    assign sb = {{WIDTH{b[WIDTH-1]}}, b};
    assign ua = {{WIDTH{1'b0}}, a};
    assign ub = {{WIDTH{1'b0}}, b};

    always_comb begin
        res  = '0;
        keep = 1'b0;
        quo  = '0;
        rem  = '0;
        case (op)
            MULT, MADD, MSUB: res = sa * sb;
            MULTU, MADDU, MSUBU: res = ua * ub;
            DIV: begin
                if (b == '0) begin
                    keep = 1'b1;
                end else if (a == MIN_INT && b == '1) begin
                    res = {{WIDTH{1'b0}}, MIN_INT};
                end else begin
                    quo = $signed(a) / $signed(b);
                    rem = $signed(a) % $signed(b);
                    res = {rem, quo};
                end
            end
            DIVU: begin
                if (b == '0) keep = 1'b1;
                else res = {a % b, a / b};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_multicycle.sv
// Multi-cycle MDU with HI/LO, cancel and fixed op-dependent latency.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulation into {hi,lo}.
module mdu_multicycle
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);

    state_e             state;
    state_e             state_n;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_n;
    logic [2*WIDTH-1:0] stg_res;
    acc_e               stg_acc;
    logic [2*WIDTH-1:0] arith_res;
    logic               arith_keep;
    acc_e               acc_sel;
    logic [2*WIDTH-1:0] commit_val;
    logic               issue_ok;
    logic               accept;
    logic               commit;
    logic               wr_hi;
    logic               wr_lo;

    mdu_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op   (op),
        .a    (src_a),
        .b    (src_b),
        .res  (arith_res),
        .keep (arith_keep)
    );

    assign busy     = (state == BUSY);
    assign issue_ok = start && !busy && !cancel;
    assign accept   = issue_ok && (state == IDLE)
                   && (is_mul(op) || is_div(op));
    assign wr_hi    = issue_ok && (op == MTHI);
    assign wr_lo    = issue_ok && (op == MTLO);
    assign commit   = busy && (cnt == CW'(1)) && !cancel;

    always_comb begin
        acc_sel = ACC_LOAD;
        if (arith_keep) acc_sel = ACC_KEEP;
        else if (op == MADD || op == MADDU) acc_sel = ACC_ADD;
        else if (op == MSUB || op == MSUBU) acc_sel = ACC_SUB;
    end

    // Accumulate against hi/lo as they stand on the commit edge
    always_comb begin
        commit_val = stg_res;
        case (stg_acc)
            ACC_ADD: commit_val = {hi, lo} + stg_res;
            ACC_SUB: commit_val = {hi, lo} - stg_res;
            ACC_KEEP: commit_val = {hi, lo};
            default: commit_val = stg_res;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = BUSY;
                    cnt_n   = is_div(op) ? DIV_CNT : MUL_CNT;
                end
            end
            BUSY: begin
                if (cancel || cnt == CW'(1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            stg_res <= '0;
            stg_acc <= ACC_LOAD;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                stg_res <= arith_res;
                stg_acc <= acc_sel;
            end
            if (commit) begin
                hi <= commit_val[2*WIDTH-1:WIDTH];
                lo <= commit_val[WIDTH-1:0];
            end
            if (wr_hi) hi <= src_a;
            if (wr_lo) lo <= src_a;
        end
    end

    always_comb begin
        rd_data = '0;
        if (op == MFHI) rd_data = hi;
        else if (op == MFLO) rd_data = lo;
    end

endmodule

// File: tb/tb_mdu_multicycle.sv
// Directed self-checking bench for mdu_multicycle (default parameters).
// MDU_MADD_EN selects the accumulate checks instead of the ignored-op check.
module tb_mdu_multicycle;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int n_cmp = 0;
    int n_err = 0;
    int ncyc;

    mdu_multicycle #(
        .WIDTH   (32),
        .MUL_LAT (5),
        .DIV_LAT (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .cancel  (cancel),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        step();
        start = 1'b0;
        op    = NONE;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 64) begin
            n++;
            step();
        end
        chk("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [3:0] o,
                      input logic [31:0] exp);
        op = o;
        #1;
        chk(tag, rd_data, exp);
        op = NONE;
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        op     = NONE;
        src_a  = '0;
        src_b  = '0;
        cancel = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd", rd_data, 32'h0);

        issue(MULT, 32'hFFFF_FFFD, 32'd7);
        wait_idle(ncyc);
        chk("mult_lat", ncyc, 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);
        rd("mfhi_rd", MFHI, 32'hFFFF_FFFF);

        issue(MULTU, 32'hFFFF_FFFD, 32'd7);
        wait_idle(ncyc);
        chk("multu_hi", hi, 32'h0000_0006);
        chk("multu_lo", lo, 32'hFFFF_FFEB);

        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(ncyc);
        chk("div_lat", ncyc, 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(ncyc);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0);

        issue(DIVU, 32'd5, 32'd0);
        wait_idle(ncyc);
        chk("dz_lat", ncyc, 32'd10);
        chk("dz_lo", lo, 32'h8000_0000);
        chk("dz_hi", hi, 32'h0);

        issue(DIV, 32'd100, 32'd7);
        step();
        step();
        step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        chk("cancel_lo", lo, 32'h8000_0000);
        chk("cancel_hi", hi, 32'h0);

        issue(MULT, 32'd4, 32'd4);
        step();
        step();
        step();
        step();
        chk("pre_commit_busy", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("commit_cancel_busy", {31'd0, busy}, 32'd0);
        chk("commit_cancel_lo", lo, 32'h8000_0000);

        cancel = 1'b1;
        issue(MULT, 32'd3, 32'd3);
        cancel = 1'b0;
        chk("start_cancel_busy", {31'd0, busy}, 32'd0);
        cancel = 1'b1;
        issue(MTLO, 32'hBEEF, 32'd0);
        cancel = 1'b0;
        chk("start_cancel_lo", lo, 32'h8000_0000);

        issue(MTLO, 32'h1234, 32'd0);
        chk("mtlo_lo", lo, 32'h1234);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        rd("mflo_rd", MFLO, 32'h1234);

        issue(MULT, 32'd2, 32'd3);
        issue(MTHI, 32'hDEAD, 32'd0);
        chk("mthi_busy_hi", hi, 32'h0);
        issue(MULT, 32'd5, 32'd5);
        wait_idle(ncyc);
        chk("restart_lat", ncyc, 32'd3);
        chk("restart_lo", lo, 32'd6);
        chk("restart_hi", hi, 32'd0);

        issue(4'd13, 32'd2, 32'd3);
        chk("badop_busy", {31'd0, busy}, 32'd0);
        chk("badop_lo", lo, 32'd6);

`ifdef MDU_MADD_EN
        issue(MTHI, 32'd0, 32'd0);
        issue(MTLO, 32'd10, 32'd0);
        issue(MADD, 32'd2, 32'd3);
        wait_idle(ncyc);
        chk("madd_lat", ncyc, 32'd5);
        chk("madd_lo", lo, 32'd16);
        chk("madd_hi", hi, 32'd0);
        issue(MSUB, 32'd2, 32'd3);
        wait_idle(ncyc);
        chk("msub_lo", lo, 32'd10);
        chk("msub_hi", hi, 32'd0);
`else
        issue(MADD, 32'd2, 32'd3);
        chk("madd_off_busy", {31'd0, busy}, 32'd0);
        step();
        chk("madd_off_lo", lo, 32'd6);
        chk("madd_off_hi", hi, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
